// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect trap).
package fetch_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_e;

  // Plain-vector encodings of the fetch states for use in state registers.
  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_TRAP = TRAP;

  // Force a PC onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for {inst, pc} bundles. Head is read straight from the
// storage register selected by the read pointer, so a push is visible one
// cycle later. Flush empties the FIFO and wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited request issue, in-order
// response capture into the prefetch FIFO, and redirect flush with stale
// response discard.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the TRAP state and the
// out_misaligned port for redirects to non-word-aligned targets.
//
// state | meaning
// BOOT  | first cycle after reset release, no request issued
// RUN   | normal fetching
// TRAP  | misaligned redirect seen; emit one NOP bundle, then idle until redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            out_misaligned
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       inflight;
  logic [2*XLEN-1:0] fifo_head;
  logic              fire;
  logic              fifo_valid;
  logic              fifo_pop;
  logic              rsp_drop;
  logic              push;
  logic              credit_ok;
  logic              trap_emit;

`ifdef FETCH_ALIGN_CHECK_EN
  logic            trap_pending;
  logic [XLEN-1:0] trap_pc;
  logic            redirect_misaligned;

  assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
  // The NOP bundle waits until every stale response has drained.
  assign trap_emit = (state == ST_TRAP) && trap_pending && (outstanding == '0);

  // Remember the misaligned target until its NOP bundle is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pending <= 1'b0;
      trap_pc      <= '0;
    end else if (redirect_valid) begin
      trap_pending <= redirect_misaligned;
      trap_pc      <= redirect_pc;
    end else if (trap_emit && out_ready) begin
      trap_pending <= 1'b0;
    end
  end
`else
  assign trap_emit = 1'b0;
`endif

  assign fifo_valid = fifo_count != '0;
  assign fifo_pop   = fifo_valid && out_ready;

  // A pop this cycle is already committed, so its slot counts as free. This
  // keeps one bundle per cycle with single-cycle memory at depth 2, and the
  // request stays valid afterwards because the freed slot is then reflected
  // in fifo_count.
  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};
  assign credit_ok = inflight < (CW + 1)'(FIFO_DEPTH);

  assign imem_req_valid = (state == ST_RUN) && credit_ok;
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign push     = imem_rsp_valid && !rsp_drop && !redirect_valid;

  assign outstanding_next = outstanding + CW'(fire) - CW'(imem_rsp_valid);

  // Next state: redirect dominates, BOOT always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
      state_next = redirect_misaligned ? ST_TRAP : ST_RUN;
`else
      state_next = ST_RUN;
`endif
    end else if (state == ST_BOOT) begin
      state_next = ST_RUN;
    end
  end

  // PC, response PC tracking and in-flight bookkeeping. Every request still
  // in flight after a redirect is stale, including one fired in the redirect
  // cycle; drop_cnt is therefore set to the full post-redirect in-flight count
  // (already-stale requests are part of that count, so they are not added twice).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc       <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop_cnt <= outstanding_next;
      end else begin
        if (fire)     pc       <= pc + PC_STEP;
        if (push)     rsp_pc   <= rsp_pc + PC_STEP;
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_valid = fifo_valid || trap_emit;
`ifdef FETCH_ALIGN_CHECK_EN
  assign out_inst       = trap_emit ? NOP_INST : fifo_head[2*XLEN-1:XLEN];
  assign out_pc         = trap_emit ? trap_pc  : fifo_head[XLEN-1:0];
  assign out_misaligned = trap_emit;
`else
  assign out_inst = fifo_head[2*XLEN-1:XLEN];
  assign out_pc   = fifo_head[XLEN-1:0];
`endif

endmodule
